// File: rtl/result_read_fsm.sv
// Drain side of the result ring buffer: counts filled slots, reads them back word by word
// and streams them out. Optional byte-enable output is enabled by defining RESULT_READ_KEEP_EN.
module result_read_fsm #(
  parameter int NUM_SLOTS   = 5,
  parameter int SLOT_STRIDE = 1550,
  parameter int ADDR_W      = 32,
  parameter int LEN_W       = 11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              slot_done,
  input  logic [LEN_W-1:0]  slot_len,
  output logic              read_req,
  output logic [ADDR_W-1:0] read_addr,
  input  logic              read_ack,
  input  logic [31:0]       rd_data,
  output logic              out_valid,
  output logic [31:0]       out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              slots_full,
`ifdef RESULT_READ_KEEP_EN
  output logic [3:0]        out_keep,
`endif
  output logic              overflow
);

  localparam int CNT_W = $clog2(NUM_SLOTS + 1);
  localparam int PTR_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam logic [CNT_W-1:0]  PENDING_MAX = CNT_W'(NUM_SLOTS);
  localparam logic [PTR_W-1:0]  PTR_LAST    = PTR_W'(NUM_SLOTS - 1);
  localparam logic [ADDR_W-1:0] STRIDE_A    = ADDR_W'(SLOT_STRIDE);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    OUT     = 2'd2,
    RELEASE = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  pending_q, pending_d;
  logic [PTR_W-1:0]  wrPtr_q, wrPtr_d;
  logic [PTR_W-1:0]  rdPtr_q, rdPtr_d;
  logic [PTR_W-1:0]  slotIdx_q, slotIdx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] readAddr_q, readAddr_d;
  logic [LEN_W-1:0]  remaining_q, remaining_d;
  logic [LEN_W-1:0]  curLen_q, curLen_d;
  logic [31:0]       outData_q, outData_d;
  logic              outLast_q, outLast_d;
  logic              slotsFull_q, slotsFull_d;
  logic              overflow_q, overflow_d;
`ifdef RESULT_READ_KEEP_EN
  logic [3:0]        keep_q, keep_d;
`endif

  logic [LEN_W-1:0]  lenMem [NUM_SLOTS];
  logic [LEN_W-1:0]  lenClamped;
  logic [LEN_W-1:0]  headLen;
  logic [LEN_W:0]    headRounded;
  logic [LEN_W-1:0]  headWords;
  logic              pushEn;
  logic              popEn;
  logic              releaseEn;

  // Lengths beyond one slot cannot be valid data, so they are capped to the slot size.
  always_comb begin
    lenClamped = slot_len;
    if (int'(slot_len) > SLOT_STRIDE) begin
      lenClamped = LEN_W'(SLOT_STRIDE);
    end
  end

  always_comb begin
    headLen     = lenMem[rdPtr_q];
    headRounded = {1'b0, headLen} + (LEN_W + 1)'(3);
    headWords   = headRounded[LEN_W:2] ;
  end

  // A release in the same cycle frees a slot, so a push is still accepted when full.
  always_comb begin
    releaseEn = (state_q == RELEASE);
    popEn     = (state_q == IDLE) && (pending_q != '0);
    pushEn    = slot_done && ((pending_q != PENDING_MAX) || releaseEn);
    wrPtr_d   = wrPtr_q;
    rdPtr_d   = rdPtr_q;
    pending_d = pending_q;
    if (pushEn) begin
      wrPtr_d = (wrPtr_q == PTR_LAST) ? '0 : wrPtr_q + PTR_W'(1);
    end
    if (popEn) begin
      rdPtr_d = (rdPtr_q == PTR_LAST) ? '0 : rdPtr_q + PTR_W'(1);
    end
    if (pushEn && !releaseEn) begin
      pending_d = pending_q + CNT_W'(1);
    end else if (!pushEn && releaseEn) begin
      pending_d = pending_q - CNT_W'(1);
    end
    overflow_d  = overflow_q | (slot_done && !pushEn);
    slotsFull_d = (pending_q == PENDING_MAX);
  end

  always_comb begin
    state_d     = state_q;
    readAddr_d  = readAddr_q;
    remaining_d = remaining_q;
    curLen_d    = curLen_q;
    outData_d   = outData_q;
    outLast_d   = outLast_q;
    slotIdx_d   = slotIdx_q;
    base_d      = base_q;
`ifdef RESULT_READ_KEEP_EN
    keep_d      = keep_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (popEn) begin
          curLen_d    = headLen;
          remaining_d = headWords;
          readAddr_d  = base_q;
          state_d     = (headLen == '0) ? RELEASE : REQ;
        end
      end
      REQ: begin
        if (read_ack) begin
          outData_d = rd_data;
          outLast_d = (remaining_q == LEN_W'(1));
`ifdef RESULT_READ_KEEP_EN
          keep_d = 4'b1111;
          if (remaining_q == LEN_W'(1)) begin
            unique case (curLen_q[1:0])
              2'b01:   keep_d = 4'b0001;
              2'b10:   keep_d = 4'b0011;
              2'b11:   keep_d = 4'b0111;
              default: keep_d = 4'b1111;
            endcase
          end
`endif
          state_d = OUT;
        end
      end
      OUT: begin
        if (out_ready) begin
          outLast_d = 1'b0;
          if (outLast_q) begin
            state_d = RELEASE;
          end else begin
            readAddr_d  = readAddr_q + ADDR_W'(4);
            remaining_d = remaining_q - LEN_W'(1);
            state_d     = REQ;
          end
        end
      end
      RELEASE: begin
        if (slotIdx_q == PTR_LAST) begin
          slotIdx_d = '0;
          base_d    = '0;
        end else begin
          slotIdx_d = slotIdx_q + PTR_W'(1);
          base_d    = base_q + STRIDE_A;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q   <= '0;
      wrPtr_q     <= '0;
      rdPtr_q     <= '0;
      slotIdx_q   <= '0;
      base_q      <= '0;
      readAddr_q  <= '0;
      remaining_q <= '0;
      curLen_q    <= '0;
      outData_q   <= '0;
      outLast_q   <= 1'b0;
      slotsFull_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pending_q   <= pending_d;
      wrPtr_q     <= wrPtr_d;
      rdPtr_q     <= rdPtr_d;
      slotIdx_q   <= slotIdx_d;
      base_q      <= base_d;
      readAddr_q  <= readAddr_d;
      remaining_q <= remaining_d;
      curLen_q    <= curLen_d;
      outData_q   <= outData_d;
      outLast_q   <= outLast_d;
      slotsFull_q <= slotsFull_d;
      overflow_q  <= overflow_d;
    end
  end

`ifdef RESULT_READ_KEEP_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      keep_q <= 4'b0000;
    end else begin
      keep_q <= keep_d;
    end
  end

  assign out_keep = keep_q;
`endif

  // Storage only; occupancy is tracked by the pointers, so no reset is needed.
  always_ff @(posedge clk) begin
    if (pushEn) begin
      lenMem[wrPtr_q] <= lenClamped;
    end
  end

  assign read_req   = (state_q == REQ);
  assign out_valid  = (state_q == OUT);
  assign read_addr  = readAddr_q;
  assign out_data   = outData_q;
  assign out_last   = outLast_q;
  assign slots_full = slotsFull_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_result_read_fsm.sv
// Directed bench for result_read_fsm: a cycle-by-cycle vector table for the basic drain,
// followed by hand-written sequences for reset, wrap, full/overflow, backpressure and lengths.
module tb_result_read_fsm;

  logic        clk = 1'b0;
  logic        rst;
  logic        slotDone;
  logic [10:0] slotLen;
  logic        readReq;
  logic [31:0] readAddr;
  logic        readAck;
  logic [31:0] rdData;
  logic        outValid;
  logic [31:0] outData;
  logic        outLast;
  logic        outReady;
  logic        slotsFull;
  logic        overflow;
`ifdef RESULT_READ_KEEP_EN
  logic [3:0]  outKeep;
`endif

  int vectorCount = 0;
  int missCount   = 0;

  result_read_fsm dut (
    .clk        (clk),
    .rst        (rst),
    .slot_done  (slotDone),
    .slot_len   (slotLen),
    .read_req   (readReq),
    .read_addr  (readAddr),
    .read_ack   (readAck),
    .rd_data    (rdData),
    .out_valid  (outValid),
    .out_data   (outData),
    .out_last   (outLast),
    .out_ready  (outReady),
    .slots_full (slotsFull),
`ifdef RESULT_READ_KEEP_EN
    .out_keep   (outKeep),
`endif
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        sd;
    logic [10:0] len;
    logic        eReq;
    logic [31:0] eAddr;
    logic        eValid;
    logic [31:0] eData;
    logic        eLast;
  } vec_t;

  vec_t vecTable [20];

  function automatic vec_t mkVec(logic sd, logic [10:0] len, logic eReq, logic [31:0] eAddr,
                                 logic eValid, logic [31:0] eData, logic eLast);
    vec_t v;
    v.sd = sd; v.len = len; v.eReq = eReq; v.eAddr = eAddr;
    v.eValid = eValid; v.eData = eData; v.eLast = eLast;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectorCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic doReset();
    rst      = 1'b1;
    slotDone = 1'b0;
    slotLen  = '0;
    readAck  = 1'b0;
    rdData   = '0;
    outReady = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic pulseSlot(input logic [10:0] len);
    @(negedge clk);
    slotDone = 1'b1;
    slotLen  = len;
    @(negedge clk);
    slotDone = 1'b0;
  endtask

  task automatic applyStimulus(input int i);
    @(negedge clk);
    slotDone = vecTable[i].sd;
    slotLen  = vecTable[i].len;
    rdData   = 32'hC0DE_0000 + 32'(i);
    #1;
    checkOutput($sformatf("vec%0d.req", i),   readReq,   vecTable[i].eReq);
    checkOutput($sformatf("vec%0d.addr", i),  readAddr,  vecTable[i].eAddr);
    checkOutput($sformatf("vec%0d.valid", i), outValid,  vecTable[i].eValid);
    checkOutput($sformatf("vec%0d.data", i),  outData,   vecTable[i].eData);
    checkOutput($sformatf("vec%0d.last", i),  outLast,   vecTable[i].eLast);
    checkOutput($sformatf("vec%0d.full", i),  slotsFull, 1'b0);
    checkOutput($sformatf("vec%0d.ovf", i),   overflow,  1'b0);
  endtask

  initial begin
    logic [31:0] wrapBase [6];
    int          words;
    int          lasts;
    int          lastIdx;
    logic [31:0] lastAddr;
    logic        found;

    // Slot of 10 bytes, then a zero-length slot, then a 5-byte slot in the next base.
    vecTable[0]  = mkVec(1'b1, 11'd10, 1'b0, 32'h0,   1'b0, 32'h0,         1'b0);
    vecTable[1]  = mkVec(1'b0, 11'd0,  1'b0, 32'h0,   1'b0, 32'h0,         1'b0);
    vecTable[2]  = mkVec(1'b0, 11'd0,  1'b1, 32'h0,   1'b0, 32'h0,         1'b0);
    vecTable[3]  = mkVec(1'b0, 11'd0,  1'b0, 32'h0,   1'b1, 32'hC0DE_0002, 1'b0);
    vecTable[4]  = mkVec(1'b0, 11'd0,  1'b1, 32'h4,   1'b0, 32'hC0DE_0002, 1'b0);
    vecTable[5]  = mkVec(1'b0, 11'd0,  1'b0, 32'h4,   1'b1, 32'hC0DE_0004, 1'b0);
    vecTable[6]  = mkVec(1'b0, 11'd0,  1'b1, 32'h8,   1'b0, 32'hC0DE_0004, 1'b0);
    vecTable[7]  = mkVec(1'b0, 11'd0,  1'b0, 32'h8,   1'b1, 32'hC0DE_0006, 1'b1);
    vecTable[8]  = mkVec(1'b0, 11'd0,  1'b0, 32'h8,   1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[9]  = mkVec(1'b1, 11'd0,  1'b0, 32'h8,   1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[10] = mkVec(1'b0, 11'd0,  1'b0, 32'h8,   1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[11] = mkVec(1'b0, 11'd0,  1'b0, 32'h60E, 1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[12] = mkVec(1'b1, 11'd5,  1'b0, 32'h60E, 1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[13] = mkVec(1'b0, 11'd0,  1'b0, 32'h60E, 1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[14] = mkVec(1'b0, 11'd0,  1'b1, 32'hC1C, 1'b0, 32'hC0DE_0006, 1'b0);
    vecTable[15] = mkVec(1'b0, 11'd0,  1'b0, 32'hC1C, 1'b1, 32'hC0DE_000E, 1'b0);
    vecTable[16] = mkVec(1'b0, 11'd0,  1'b1, 32'hC20, 1'b0, 32'hC0DE_000E, 1'b0);
    vecTable[17] = mkVec(1'b0, 11'd0,  1'b0, 32'hC20, 1'b1, 32'hC0DE_0010, 1'b1);
    vecTable[18] = mkVec(1'b0, 11'd0,  1'b0, 32'hC20, 1'b0, 32'hC0DE_0010, 1'b0);
    vecTable[19] = mkVec(1'b0, 11'd0,  1'b0, 32'hC20, 1'b0, 32'hC0DE_0010, 1'b0);

    wrapBase = '{32'h0, 32'h60E, 32'hC1C, 32'h122A, 32'h1838, 32'h0};

    $display("[TB] table-driven basic drain");
    doReset();
    readAck  = 1'b1;
    outReady = 1'b1;
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i);
    end

    $display("[TB] asynchronous reset in the middle of a slot");
    doReset();
    readAck  = 1'b1;
    outReady = 1'b1;
    rdData   = 32'hABCD_1234;
    pulseSlot(11'd8);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (outValid) found = 1'b1;
    end
    checkOutput("rst.firstWordSeen", found, 1'b1);
    readAck = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (readReq) found = 1'b1;
    end
    checkOutput("rst.secondReqSeen", found, 1'b1);
    checkOutput("rst.preAddr", readAddr, 32'h4);
    checkOutput("rst.preData", outData, 32'hABCD_1234);
    rst = 1'b1;
    #1;
    checkOutput("rst.req",   readReq,   1'b0);
    checkOutput("rst.addr",  readAddr,  32'h0);
    checkOutput("rst.valid", outValid,  1'b0);
    checkOutput("rst.data",  outData,   32'h0);
    checkOutput("rst.last",  outLast,   1'b0);
    checkOutput("rst.full",  slotsFull, 1'b0);
    checkOutput("rst.ovf",   overflow,  1'b0);

    $display("[TB] slot index wrap");
    doReset();
    readAck  = 1'b1;
    outReady = 1'b1;
    for (int s = 0; s < 6; s++) begin
      pulseSlot(11'd4);
      found = 1'b0;
      for (int c = 0; c < 10 && !found; c++) begin
        @(negedge clk);
        if (readReq) begin
          found = 1'b1;
          checkOutput($sformatf("wrap.base%0d", s), readAddr, wrapBase[s]);
        end
      end
      checkOutput($sformatf("wrap.req%0d", s), found, 1'b1);
      repeat (4) @(negedge clk);
    end

    $display("[TB] full and overflow");
    doReset();
    readAck  = 1'b1;
    outReady = 1'b0;
    @(negedge clk);
    for (int s = 0; s < 5; s++) begin
      slotDone = 1'b1;
      slotLen  = 11'd4;
      @(negedge clk);
    end
    slotDone = 1'b0;
    @(negedge clk);
    checkOutput("full.full", slotsFull, 1'b1);
    checkOutput("full.ovfClear", overflow, 1'b0);
    checkOutput("full.stalled", outValid, 1'b1);
    slotDone = 1'b1;
    @(negedge clk);
    slotDone = 1'b0;
    checkOutput("full.ovfSet", overflow, 1'b1);
    outReady = 1'b1;
    @(negedge clk);
    outReady = 1'b0;
    slotDone = 1'b1;
    @(negedge clk);
    slotDone = 1'b0;
    @(negedge clk);
    checkOutput("full.stillFull", slotsFull, 1'b1);
    outReady = 1'b1;
    lasts = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (outValid && outLast) lasts++;
    end
    checkOutput("full.remainingSlots", lasts, 5);
    checkOutput("full.drained", slotsFull, 1'b0);
    checkOutput("full.ovfSticky", overflow, 1'b1);

    $display("[TB] backpressure and delayed acknowledge");
    doReset();
    readAck  = 1'b0;
    outReady = 1'b1;
    pulseSlot(11'd12);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (readReq) found = 1'b1;
    end
    checkOutput("bp.reqSeen", found, 1'b1);
    for (int c = 0; c < 3; c++) begin
      checkOutput($sformatf("bp.ackWaitReq%0d", c), readReq, 1'b1);
      checkOutput($sformatf("bp.ackWaitAddr%0d", c), readAddr, 32'h0);
      @(negedge clk);
    end
    readAck = 1'b1;
    rdData  = 32'h1111_0001;
    @(negedge clk);
    checkOutput("bp.word1Valid", outValid, 1'b1);
    checkOutput("bp.word1Data", outData, 32'h1111_0001);
    rdData = 32'h2222_0002;
    @(negedge clk);
    checkOutput("bp.word2Req", readReq, 1'b1);
    checkOutput("bp.word2Addr", readAddr, 32'h4);
    outReady = 1'b0;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("bp.holdValid%0d", c), outValid, 1'b1);
      checkOutput($sformatf("bp.holdData%0d", c), outData, 32'h2222_0002);
      checkOutput($sformatf("bp.holdLast%0d", c), outLast, 1'b0);
      checkOutput($sformatf("bp.holdNoReq%0d", c), readReq, 1'b0);
    end
    outReady = 1'b1;
    rdData   = 32'h3333_0003;
    @(negedge clk);
    checkOutput("bp.word3Addr", readAddr, 32'h8);
    @(negedge clk);
    checkOutput("bp.word3Data", outData, 32'h3333_0003);
    checkOutput("bp.word3Last", outLast, 1'b1);

    $display("[TB] oversized length");
    doReset();
    readAck  = 1'b1;
    outReady = 1'b1;
    rdData   = 32'h5A5A_5A5A;
    pulseSlot(11'd2000);
    words    = 0;
    lasts    = 0;
    lastIdx  = 0;
    lastAddr = '0;
    for (int c = 0; c < 900; c++) begin
      @(negedge clk);
      if (readReq) lastAddr = readAddr;
      if (outValid) begin
        words++;
`ifdef RESULT_READ_KEEP_EN
        checkOutput($sformatf("big.keep%0d", words), outKeep, outLast ? 4'b0011 : 4'b1111);
`endif
        if (outLast) begin
          lasts++;
          lastIdx = words;
        end
      end
    end
    checkOutput("big.words", words, 388);
    checkOutput("big.lastCount", lasts, 1);
    checkOutput("big.lastIndex", lastIdx, 388);
    checkOutput("big.lastAddr", lastAddr, 32'h60C);

    $display("[TB] == %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
